// File: rtl/hazard_stall_control_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_control_pkg
// Shared pipeline constants: the memory-stall FSM state encoding and the
// architectural zero register address.
// ---------------------------------------------------------------------------
package hazard_stall_control_pkg;

    // Memory-stall FSM encoding (2-bit, legacy-compatible constants)
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard
    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_stall_control_load_use.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use comparator: flags when the load in EX writes a
// register the instruction in ID reads.
//   ID_RS1addr_i / ID_RS2addr_i : source registers of the ID instruction
//   EX_MemRead_i                : EX instruction is a load
//   EX_RDaddr_i                 : destination register of the EX instruction
//   load_use_o                  : 1 when ID must wait one cycle for the load
// ---------------------------------------------------------------------------
module load_use_detect
    import hazard_stall_control_pkg::*;
(
    input  logic [4:0] ID_RS1addr_i,
    input  logic [4:0] ID_RS2addr_i,
    input  logic       EX_MemRead_i,
    input  logic [4:0] EX_RDaddr_i,
    output logic       load_use_o
);

    assign load_use_o = EX_MemRead_i
                      & (EX_RDaddr_i != REG_X0)
                      & ((EX_RDaddr_i == ID_RS1addr_i) | (EX_RDaddr_i == ID_RS2addr_i));

endmodule

// File: rtl/hazard_stall_control.sv
// ---------------------------------------------------------------------------
// hazard_stall_control
// Pipeline hazard unit: freezes the pipe for data-cache accesses, inserts a
// bubble on load-use hazards, flushes IF/ID on taken branches, and counts
// stall cycles.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   ID_RS1addr_i/RS2     : ID source registers
//   EX_MemRead_i/RDaddr  : EX load and its destination
//   Branch_taken_i       : branch resolved taken in ID
//   MEM_MemRead_i/Write  : MEM stage cache access
//   mem_ack_i            : cache access complete
//   mem_req_o            : cache access request
//   pipe_stall_o         : freeze all pipeline registers and PC
//   PC_write_o           : PC update enable
//   IFID_write_o         : IF/ID write enable
//   IDEX_bubble_o        : insert a NOP into ID/EX
//   IFID_flush_o         : clear IF/ID
//   stall_cnt_o          : saturating stall-cycle count
//
// Handshake: mem_req_o rises combinationally in the first cycle of an access
// and stays high until the edge on which mem_ack_i is sampled high (WAIT
// only); the following RELEASE cycle drops the request and lets the pipe
// advance once. mem_ack_i outside WAIT is ignored.
// ---------------------------------------------------------------------------
module hazard_stall_control
    import hazard_stall_control_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [4:0]             ID_RS1addr_i,
    input  logic [4:0]             ID_RS2addr_i,
    input  logic                   EX_MemRead_i,
    input  logic [4:0]             EX_RDaddr_i,
    input  logic                   Branch_taken_i,
    input  logic                   MEM_MemRead_i,
    input  logic                   MEM_MemWrite_i,
    input  logic                   mem_ack_i,
    output logic                   mem_req_o,
    output logic                   pipe_stall_o,
    output logic                   PC_write_o,
    output logic                   IFID_write_o,
    output logic                   IDEX_bubble_o,
    output logic                   IFID_flush_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    logic [1:0]             state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   mem_access;
    logic                   mem_stall;
    logic                   load_use;

    assign mem_access = MEM_MemRead_i | MEM_MemWrite_i;

    load_use_detect u_load_use (
        .ID_RS1addr_i (ID_RS1addr_i),
        .ID_RS2addr_i (ID_RS2addr_i),
        .EX_MemRead_i (EX_MemRead_i),
        .EX_RDaddr_i  (EX_RDaddr_i),
        .load_use_o   (load_use)
    );

    // Memory-stall FSM
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_access) begin
                    mem_stall = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (mem_ack_i) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // one free cycle so the completed access can leave MEM
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset overrides everything combinationally, so an abandoned request
    // drops in the very cycle reset is seen.
    assign mem_req_o    = mem_stall & ~rst_i;
    assign pipe_stall_o = mem_stall & ~rst_i;

    // Pipeline control, memory stall > load-use > branch flush
    always_comb begin
        PC_write_o    = 1'b1;
        IFID_write_o  = 1'b1;
        IDEX_bubble_o = 1'b0;
        IFID_flush_o  = 1'b0;
        if (rst_i) begin
            PC_write_o    = 1'b1;
        end else if (mem_stall) begin
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
        end else if (load_use) begin
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
        end else if (Branch_taken_i) begin
            IFID_flush_o  = 1'b1;
        end
    end

    // Saturating stall counter
    always_comb begin
        cnt_d = cnt_q;
        if ((pipe_stall_o | IDEX_bubble_o) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_stall_control.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_control
// Two instances share one stimulus stream: a default 16-bit counter and a
// 2-bit counter that exercises saturation. Expected control vectors
// {mem_req, pipe_stall, PC_write, IFID_write, IDEX_bubble, IFID_flush} and
// expected counter values are queued when a cycle is driven and popped when
// the outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_stall_control;

  localparam logic [5:0] E_IDLE  = 6'b001100;
  localparam logic [5:0] E_STALL = 6'b110000;
  localparam logic [5:0] E_LU    = 6'b000010;
  localparam logic [5:0] E_FLUSH = 6'b001101;

  // clock / reset
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mr, br, mr, mw, ack;

  logic        a_req, a_stall, a_pc, a_ifid, a_bub, a_flush;
  logic [15:0] a_cnt;
  logic        b_req, b_stall, b_pc, b_ifid, b_bub, b_flush;
  logic [1:0]  b_cnt;

  hazard_stall_control #(.STALL_CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ID_RS1addr_i(id_rs1), .ID_RS2addr_i(id_rs2),
    .EX_MemRead_i(ex_mr), .EX_RDaddr_i(ex_rd),
    .Branch_taken_i(br), .MEM_MemRead_i(mr), .MEM_MemWrite_i(mw),
    .mem_ack_i(ack), .mem_req_o(a_req), .pipe_stall_o(a_stall),
    .PC_write_o(a_pc), .IFID_write_o(a_ifid), .IDEX_bubble_o(a_bub),
    .IFID_flush_o(a_flush), .stall_cnt_o(a_cnt)
  );

  hazard_stall_control #(.STALL_CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_i),
    .ID_RS1addr_i(id_rs1), .ID_RS2addr_i(id_rs2),
    .EX_MemRead_i(ex_mr), .EX_RDaddr_i(ex_rd),
    .Branch_taken_i(br), .MEM_MemRead_i(mr), .MEM_MemWrite_i(mw),
    .mem_ack_i(ack), .mem_req_o(b_req), .pipe_stall_o(b_stall),
    .PC_write_o(b_pc), .IFID_write_o(b_ifid), .IDEX_bubble_o(b_bub),
    .IFID_flush_o(b_flush), .stall_cnt_o(b_cnt)
  );

  // scoreboard
  logic [5:0]  exp_q[$];
  logic [15:0] exp_cnt_q[$];
  logic [1:0]  exp_cnt2_q[$];
  logic [15:0] cnt_m;
  logic [1:0]  cnt2_m;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver: one clock cycle of stimulus plus its expected control vector
  task automatic apply(input string tag, input logic r,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic exm, input logic [4:0] exrd,
                       input logic b, input logic m_r, input logic m_w,
                       input logic a, input logic [5:0] e);
    logic [5:0] ctl_e;
    rst_i = r; id_rs1 = rs1; id_rs2 = rs2; ex_mr = exm; ex_rd = exrd;
    br = b; mr = m_r; mw = m_w; ack = a;
    exp_q.push_back(e);
    exp_cnt_q.push_back(cnt_m);
    exp_cnt2_q.push_back(cnt2_m);
    @(negedge clk);
    ctl_e = exp_q.pop_front();
    check_val({tag, "_ctl"}, {10'd0, a_req, a_stall, a_pc, a_ifid, a_bub, a_flush}, {10'd0, ctl_e});
    check_val({tag, "_ctl_w2"}, {10'd0, b_req, b_stall, b_pc, b_ifid, b_bub, b_flush}, {10'd0, ctl_e});
    check_val({tag, "_cnt"}, a_cnt, exp_cnt_q.pop_front());
    check_val({tag, "_cnt_w2"}, {14'd0, b_cnt}, {14'd0, exp_cnt2_q.pop_front()});
    @(posedge clk);
    #1;
    // counter model: stall or bubble in the expected vector counts one cycle
    if (r) begin
      cnt_m  = '0;
      cnt2_m = '0;
    end else if (e[4] | e[1]) begin
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      if (cnt2_m != 2'd3)    cnt2_m = cnt2_m + 2'd1;
    end
  endtask

  initial begin
    logic [4:0] r1, r2, rd;
    logic       em, bt, lu;
    cnt_m = '0; cnt2_m = '0;
    rst_i = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_mr = 1'b0; ex_rd = '0;
    br = 1'b0; mr = 1'b0; mw = 1'b0; ack = 1'b0;
    @(posedge clk); #1;

    // reset forces outputs regardless of hazards on the inputs
    apply("rst_force", 1, 5'd5, 5'd5, 1, 5'd5, 1, 1, 1, 1, E_IDLE);
    apply("idle",      0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, E_IDLE);

    // load-use on rs2, counter 0 -> 1
    apply("lu_rs2",    0, 5'd3, 5'd5, 1, 5'd5, 0, 0, 0, 0, E_LU);
    apply("lu_after",  0, 5'd3, 5'd5, 0, 5'd5, 0, 0, 0, 0, E_IDLE);
    // x0 load never stalls
    apply("x0_load",   0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0, E_IDLE);
    apply("lu_rs1",    0, 5'd7, 5'd1, 1, 5'd7, 0, 0, 0, 0, E_LU);
    apply("no_load",   0, 5'd7, 5'd1, 0, 5'd7, 0, 0, 0, 0, E_IDLE);
    // branch flush lasts exactly one cycle
    apply("flush",     0, 5'd1, 5'd2, 0, 5'd3, 1, 0, 0, 0, E_FLUSH);
    apply("flush_end", 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, E_IDLE);
    apply("lu_vs_br",  0, 5'd4, 5'd2, 1, 5'd4, 1, 0, 0, 0, E_LU);
    // ack in RUN is ignored
    apply("ack_run",   0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 1, E_IDLE);
    apply("ack_run2",  0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, E_IDLE);

    // cache miss: RUN + 4 WAIT cycles, ack on the 4th WAIT
    apply("miss_run",  0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_STALL);
    apply("miss_w1",   0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_STALL);
    apply("miss_w2",   0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_STALL);
    apply("miss_w3",   0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_STALL);
    apply("miss_w4",   0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 1, E_STALL);
    // RELEASE advances even though the access is still presented
    apply("miss_rel",  0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_IDLE);
    apply("miss_done", 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, E_IDLE);

    // memory stall outranks load-use and branch; RELEASE evaluates hazards
    apply("pri_run",   0, 5'd6, 5'd2, 1, 5'd6, 1, 0, 1, 0, E_STALL);
    apply("pri_wait",  0, 5'd6, 5'd2, 1, 5'd6, 1, 0, 1, 0, E_STALL);
    apply("pri_ack",   0, 5'd6, 5'd2, 1, 5'd6, 1, 0, 1, 1, E_STALL);
    apply("pri_rel",   0, 5'd6, 5'd2, 1, 5'd6, 1, 0, 1, 0, E_LU);
    apply("pri_run2",  0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, E_STALL);
    apply("pri_ack2",  0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 1, E_STALL);
    apply("rel_flush", 0, 5'd1, 5'd2, 0, 5'd3, 1, 0, 1, 0, E_FLUSH);
    apply("rel_done",  0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, E_IDLE);

    // reset during WAIT abandons the request; a late ack is ignored
    apply("rw_run",    0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_STALL);
    apply("rw_wait",   0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_STALL);
    apply("rw_rst",    1, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_IDLE);
    apply("rw_lateack",0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 1, E_IDLE);
    apply("rw_idle",   0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, E_IDLE);

    // five stall cycles saturate the 2-bit counter at 3
    apply("sat_run",   0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_STALL);
    apply("sat_w1",    0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_STALL);
    apply("sat_w2",    0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_STALL);
    apply("sat_w3",    0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, E_STALL);
    apply("sat_w4",    0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 1, E_STALL);
    apply("sat_rel",   0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, E_IDLE);
    apply("sat_hold",  0, 5'd4, 5'd2, 1, 5'd4, 0, 0, 0, 0, E_LU);

    // random hazard mix without memory traffic
    for (int i = 0; i < 40; i++) begin
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      em = 1'($urandom_range(0, 1));
      bt = 1'($urandom_range(0, 1));
      lu = em && (rd != 5'd0) && ((rd == r1) || (rd == r2));
      apply("rand", 0, r1, r2, em, rd, bt, 0, 0, 0,
            lu ? E_LU : (bt ? E_FLUSH : E_IDLE));
    end
    apply("final", 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, E_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
